lut_arbiter: RTL and testbench

LUT_ARBITER -- requirements
Module: lut_arbiter

---
 rtl/lut_arb_pkg.sv | 17 +
 rtl/lut_arbiter_rr_arbiter.sv | 36 +++
 rtl/lut_arbiter.sv | 82 ++++++++
 tb/tb_lut_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lut_arb_pkg.sv
// Shared defaults and helpers for the round-robin LUT read-port arbiter.
package lut_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 8;

    // Index width for n requesters, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ID_WIDTH = id_width(DEF_NUM_REQ);

    typedef logic [DEF_ID_WIDTH-1:0] grant_idx_t;

endpackage

// File: rtl/lut_arbiter_rr_arbiter.sv
// Purely combinational round-robin selector: first valid requester at or
// after the pointer wins, searching upward and wrapping to 0.
module rr_arbiter
    import lut_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ID_WIDTH = id_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  gnt_o,
    output logic [ID_WIDTH-1:0] gnt_idx_o,
    output logic                gnt_any_o
);

    int cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!gnt_any_o && req_i[cand]) begin
                gnt_any_o   = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = ID_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/lut_arbiter.sv
// Shares one registered-address LUT read port among NUM_REQ requesters with
// zero-bubble round-robin grants and a fixed one-cycle response.
module lut_arbiter
    import lut_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [ADDR_WIDTH-1:0]         o_lut_addr,
    input  logic [DATA_WIDTH-1:0]         i_lut_rdata,
    output logic                          o_rsp_valid,
    output logic [ID_WIDTH-1:0]           o_rsp_id,
    output logic [DATA_WIDTH-1:0]         o_rsp_data
);

    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;

    logic [NUM_REQ-1:0]    req_gated;
    logic [NUM_REQ-1:0]    gnt;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic                  gnt_any;
    logic [ADDR_WIDTH-1:0] sel_addr;

    // Requests are masked during reset so no grant can leak out combinationally.
    assign req_gated = i_req_valid & {NUM_REQ{i_rst_n}};

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .req_i     (req_gated),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    assign sel_addr = i_req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
        ptr_d       = ptr_q;
        addr_d      = addr_q;
        rsp_valid_d = gnt_any;
        rsp_id_d    = rsp_id_q;
        if (gnt_any) begin
            ptr_d    = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            addr_d   = sel_addr;
            rsp_id_d = gnt_idx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q       <= '0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign o_req_ready = gnt;
    assign o_lut_addr  = gnt_any ? sel_addr : addr_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_data  = rsp_valid_q ? i_lut_rdata : '0;

endmodule

// File: tb/tb_lut_arbiter.sv
// Bench for lut_arbiter: directed scenarios plus random traffic, checked
// against a round-robin model holding pointer and pending response as integers.
module tb_lut_arbiter;
    import lut_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int IW = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   lut_addr;
    logic [DW-1:0]   lut_rdata;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_ptr;
    int         m_addr;
    bit         m_pend;
    grant_idx_t m_pend_id;
    int         m_pend_data;
    int         m_wait [N];

    lut_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_addr  (req_addr),
        .o_req_ready (req_ready),
        .o_lut_addr  (lut_addr),
        .i_lut_rdata (lut_rdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LUT content: data = address
    always_ff @(posedge clk) lut_rdata <= {2'b00, lut_addr};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*AW-1:0] pack(input int a0, input int a1, input int a2, input int a3);
        logic [N*AW-1:0] r;
        r = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
        return r;
    endfunction

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_addr = 0;
        m_pend = 0;
        for (int k = 0; k < N; k++) m_wait[k] = 0;
    endtask

    // One cycle: drive at negedge, check combinational grant and the response
    // due from the previous cycle's grant, then advance the model.
    task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a);
        int w;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        req_valid = v;
        req_addr  = a;
        #1;
        w = winner(v, m_ptr);
        exp_rdy = (w >= 0) ? N'(1 << w) : '0;
        if (w >= 0) m_addr = int'(a[w*AW +: AW]);
        check("ready", 32'(req_ready), 32'(exp_rdy));
        check("lut_addr", 32'(lut_addr), 32'(m_addr));
        check("rsp_valid", 32'(rsp_valid), 32'(m_pend));
        if (m_pend) begin
            check("rsp_id", 32'(rsp_id), 32'(m_pend_id));
            check("rsp_data", 32'(rsp_data), 32'(m_pend_data));
        end
        for (int k = 0; k < N; k++) begin
            if (v[k] && k != w) m_wait[k]++;
            else m_wait[k] = 0;
            if (v[k]) check("starve_bound", 32'(m_wait[k] < N), 32'd1);
        end
        m_pend = (w >= 0);
        if (w >= 0) begin
            m_pend_id   = grant_idx_t'(w);
            m_pend_data = m_addr;
            m_ptr       = (w + 1) % N;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        req_valid = 4'b1111;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_lut_addr", 32'(lut_addr), 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;

        // Full load from pointer 0: grants 0,1,2,3 twice
        for (int c = 0; c < 8; c++) begin
            step(4'b1111, pack(8'h10, 8'h11, 8'h12, 8'h13));
            check("full_grant", 32'(req_ready), 32'(1 << (c % 4)));
        end
        step(4'b0000, '0);

        // Single request from requester 2
        step(4'b0100, pack(0, 0, 8'h15, 0));
        check("single_ready", 32'(req_ready), 32'b0100);
        step(4'b0000, '0);
        check("single_rsp_id", 32'(rsp_id), 32'd2);
        check("single_rsp_data", 32'(rsp_data), 32'h15);

        // Wrap: grant 3, then 0 and 3 together -> 0 first, then 3
        step(4'b1000, pack(0, 0, 0, 8'h33));
        step(4'b1001, pack(8'h01, 0, 0, 8'h33));
        check("wrap_first", 32'(req_ready), 32'b0001);
        step(4'b1001, pack(8'h01, 0, 0, 8'h33));
        check("wrap_second", 32'(req_ready), 32'b1000);

        // Sparse: requester 1 alone, every cycle
        for (int c = 0; c < 5; c++) step(4'b0010, pack(0, 8'h3F, 0, 0));
        check("sparse_rsp_valid", 32'(rsp_valid), 32'd1);
        check("sparse_rsp_data", 32'(rsp_data), 32'h3F);

        // Idle
        for (int c = 0; c < 10; c++) step(4'b0000, '0);
        check("idle_lut_addr_held", 32'(lut_addr), 32'h3F);

        // Reset mid-flight
        step(4'b1110, pack(0, 8'h05, 8'h06, 8'h07));
        step(4'b0001, pack(8'h2A, 0, 0, 0));
        check("mid_grant0", 32'(req_ready), 32'b0001);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        check("mid_rst_lut_addr", 32'(lut_addr), 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        step(4'b0000, '0);
        step(4'b1111, pack(8'h20, 8'h21, 8'h22, 8'h23));
        check("post_rst_grant0", 32'(req_ready), 32'b0001);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            step(N'($urandom_range(0, 15)),
                 pack($urandom_range(0, 63), $urandom_range(0, 63),
                      $urandom_range(0, 63), $urandom_range(0, 63)));
        end
        step(4'b0000, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
